yarvi_mem_arb: RTL and testbench
================================

// Module: yarvi_mem_arb
// PURPOSE
//  Arbitrates one single-ported synchronous RAM (1-cycle read latency) between
//  two requesters: FE instruction fetch (read-only) and EX load/store.
//  Sits between yarvi_fe/yarvi_ex and the shared code/data memory.
//  EX has priority; a starvation counter guarantees FE forward progress.
//  Routes each read response back to the requester that issued it.
// PARAMETERS
//  AW          30  word-address width (byte address [AW+1:2])
//  STARVE_MAX  3   consecutive denied FE cycles before FE wins one grant (>=1)
// PORTS
//  clock      in   1   clock
//  reset      in   1   asynchronous, active-high reset
//  fe_valid   in   1   FE fetch request
//  fe_ready   out  1   FE request accepted this cycle
//  fe_addr    in   AW  FE word address
//  fe_flush   in   1   FE restart: block FE grant this cycle
//  fe_rvalid  out  1   FE read data valid
//  fe_rdata   out  32  FE read data
//  ex_valid   in   1   EX load/store request
//  ex_ready   out  1   EX request accepted this cycle
//  ex_addr    in   AW  EX word address
//  ex_wmask   in   4   byte write mask; 0 = read
//  ex_wdata   in   32  EX store data
//  ex_rvalid  out  1   EX load data valid
//  ex_rdata   out  32  EX load data
//  mem_en     out  1   RAM access this cycle
//  mem_addr   out  AW  RAM word address
//  mem_wmask  out  4   RAM byte write mask (0 on reads)
//  mem_wdata  out  32  RAM write data
//  mem_rdata  in   32  RAM read data, valid the cycle after a read
// BEHAVIOUR
//  - Grant is combinational, at most one per cycle; ready = grant.
//    mem_en/addr/wmask/wdata are driven from the granted requester in the same cycle.
//  - Priority: FE wins if starve_cnt == STARVE_MAX; otherwise EX wins over FE.
//  - fe_flush=1 forces fe_ready=0 in that cycle. EX may still be granted.
//  - starve_cnt:
//    - +1 on each cycle with fe_valid & !fe_flush & !fe_ready (saturates at STARVE_MAX).
//    - Cleared on an FE grant or when fe_valid=0.
//  - Response latency is exactly 1 cycle.
//    - fe_rvalid/ex_rvalid are registered: set iff that requester had a read granted
//      in the previous cycle.
//    - fe_rdata = ex_rdata = mem_rdata.
//  - EX writes (wmask != 0) complete on handshake and produce no ex_rvalid.
//  - Requesters hold addr/wmask/wdata stable while valid & !ready; the arbiter
//    stores no request state.
//  - Hazards:
//    - A write granted in cycle N followed by a read of the same address in cycle
//      N+1 returns the new data (RAM property, no bypass here).
//    - A response in flight when fe_flush asserts is still delivered; FE discards it.
//  - Reset (async, active-high):
//    - fe_rvalid=0, ex_rvalid=0, starve_cnt=0.
//    - While reset is high: fe_ready=ex_ready=0, mem_en=0, mem_wmask=0.
//    - Reset mid-operation drops any in-flight response: no rvalid after deassertion.
//  - Invariants:
//    - Never fe_ready & ex_ready.
//    - mem_wmask != 0 only with ex_ready.
//    - FE waits at most STARVE_MAX cycles while fe_valid stays high.
// STRUCTURE
//  - Shared header yarvi.h: AW derived from `VMSB; requester-ID encoding
//    (REQ_NONE/REQ_FE/REQ_EX) used for the registered response owner.
//  - One sub-module is natural: yarvi_arb_pick, holding the combinational priority
//    and starvation compare. Counter and response registers stay in the top module.
// TESTING
//  1. After reset release, fe_valid addr 0x10, mem holds 0x00000013 -> mem_en same
//     cycle, fe_rvalid=1 next cycle, fe_rdata=0x00000013.
//  2. fe_valid and ex_valid (read) held high continuously -> EX granted cycles 0-2,
//     FE granted cycle 3 (ex_ready=0), then EX again; starve_cnt back to 0.
//  3. EX write addr 0x20, wmask 4'b0011, data 0xdeadbeef over 0x0 -> mem_wmask=0011,
//     no ex_rvalid; next-cycle FE read of 0x20 returns 0x0000beef.
//  4. fe_valid, fe_flush and ex read in the same cycle -> fe_ready=0, ex_ready=1;
//     next cycle fe_rvalid=0, ex_rvalid=1.
//  5. FE read granted, reset pulsed the next cycle -> fe_rvalid stays 0 and mem_en=0
//     during reset; normal operation resumes after deassertion.
//  6. Three back-to-back EX reads 0x4, 0x8, 0xc -> ex_rvalid high 3 consecutive
//     cycles with matching data in order.

Source files
------------

// File: rtl/yarvi_mem_arb_pkg.sv
// Shared types and helpers for the yarvi code/data memory arbiter.
package yarvi_mem_arb_pkg;

  localparam int AW_DEFAULT         = 30;
  localparam int STARVE_MAX_DEFAULT = 3;

  // Owner of the read response that returns one cycle after the grant
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_FE   = 2'd1,
    REQ_EX   = 2'd2
  } req_id_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/yarvi_mem_arb_if.sv
// FE / EX requester ports and the single-ported RAM port of the arbiter.
interface yarvi_mem_arb_if
  import yarvi_mem_arb_pkg::*;
#(
  parameter int AW = AW_DEFAULT
);
  logic          fe_valid;
  logic          fe_ready;
  logic [AW-1:0] fe_addr;
  logic          fe_flush;
  logic          fe_rvalid;
  logic [31:0]   fe_rdata;

  logic          ex_valid;
  logic          ex_ready;
  logic [AW-1:0] ex_addr;
  logic [3:0]    ex_wmask;
  logic [31:0]   ex_wdata;
  logic          ex_rvalid;
  logic [31:0]   ex_rdata;

  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  fe_valid, fe_addr, fe_flush, ex_valid, ex_addr, ex_wmask, ex_wdata, mem_rdata,
    output fe_ready, fe_rvalid, fe_rdata, ex_ready, ex_rvalid, ex_rdata,
    output mem_en, mem_addr, mem_wmask, mem_wdata
  );

  modport master (
    output fe_valid, fe_addr, fe_flush, ex_valid, ex_addr, ex_wmask, ex_wdata, mem_rdata,
    input  fe_ready, fe_rvalid, fe_rdata, ex_ready, ex_rvalid, ex_rdata,
    input  mem_en, mem_addr, mem_wmask, mem_wdata
  );

endinterface

// File: rtl/yarvi_mem_arb_pick.sv
// Combinational grant select: EX over FE unless FE has starved STARVE_MAX cycles.
module yarvi_mem_arb_pick #(
  parameter int CW         = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic          block,
  input  logic          fe_req,
  input  logic          ex_req,
  input  logic [CW-1:0] starve_cnt,
  output logic          fe_gnt,
  output logic          ex_gnt
);

  logic fe_starved;
  assign fe_starved = (starve_cnt == CW'(STARVE_MAX));

  always_comb begin
    fe_gnt = 1'b0;
    ex_gnt = 1'b0;
    if (!block) begin
      if (fe_req && fe_starved) begin
        fe_gnt = 1'b1;
      end else if (ex_req) begin
        ex_gnt = 1'b1;
      end else if (fe_req) begin
        fe_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/yarvi_mem_arb.sv
// Shares one 1-cycle-latency RAM between FE fetch and EX load/store; the arbiter
// holds no request state, only the FE starvation counter and the response owner.
module yarvi_mem_arb
  import yarvi_mem_arb_pkg::*;
#(
  parameter int AW         = AW_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  yarvi_mem_arb_if.slave  bus
);

  localparam int CW = cnt_width(STARVE_MAX);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  req_id_t       rsp_owner_q, rsp_owner_d;
  logic          fe_gnt, ex_gnt;
  logic          fe_req;
  logic [AW-1:0] mem_addr_sel;

  assign fe_req = bus.fe_valid & ~bus.fe_flush;

  // Reset blocks both grants so nothing reaches the RAM while it is held
  yarvi_mem_arb_pick #(
    .CW         (CW),
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .block      (reset),
    .fe_req     (fe_req),
    .ex_req     (bus.ex_valid),
    .starve_cnt (starve_cnt_q),
    .fe_gnt     (fe_gnt),
    .ex_gnt     (ex_gnt)
  );

  // A flushed cycle neither counts as a denial nor clears the count
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.fe_valid || fe_gnt) begin
      starve_cnt_d = '0;
    end else if (!bus.fe_flush && starve_cnt_q != CW'(STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_comb begin
    rsp_owner_d = REQ_NONE;
    if (fe_gnt) begin
      rsp_owner_d = REQ_FE;
    end else if (ex_gnt && bus.ex_wmask == 4'b0000) begin
      rsp_owner_d = REQ_EX;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
      rsp_owner_q  <= REQ_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsp_owner_q  <= rsp_owner_d;
    end
  end

  assign mem_addr_sel  = ex_gnt ? bus.ex_addr : bus.fe_addr;

  assign bus.fe_ready  = fe_gnt;
  assign bus.ex_ready  = ex_gnt;
  assign bus.mem_en    = fe_gnt | ex_gnt;
  assign bus.mem_addr  = mem_addr_sel;
  assign bus.mem_wmask = ex_gnt ? bus.ex_wmask : 4'b0000;
  assign bus.mem_wdata = bus.ex_wdata;

  assign bus.fe_rvalid = (rsp_owner_q == REQ_FE);
  assign bus.ex_rvalid = (rsp_owner_q == REQ_EX);
  assign bus.fe_rdata  = bus.mem_rdata;
  assign bus.ex_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_yarvi_mem_arb.sv
// Bench for yarvi_mem_arb: RAM model, response scoreboard and directed scenarios.
module tb_yarvi_mem_arb;
  import yarvi_mem_arb_pkg::*;

  localparam int AW         = 30;
  localparam int STARVE_MAX = 3;

  typedef struct {
    int          cyc;
    bit          is_fe;
    logic [31:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  yarvi_mem_arb_if #(.AW(AW)) bus ();

  yarvi_mem_arb #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];
  exp_t        exp_q   [$];
  int          checks   = 0;
  int          errors   = 0;
  int          cyc      = 0;
  int          fe_wait  = 0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 16'h10) return 32'h0000_0013;
    if (i == 16'h20) return 32'h0000_0000;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.fe_valid = 1'b0;
    bus.fe_flush = 1'b0;
    bus.ex_valid = 1'b0;
    bus.ex_wmask = 4'b0000;
  endtask

  // RAM: synchronous read, byte-masked write
  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_wmask != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_wmask[b]) ram[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= ram[bus.mem_addr[7:0]];
      end
    end
  end

  // Scoreboard and invariants, sampled mid-cycle
  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (reset) begin
      exp_q.delete();
      fe_wait = 0;
    end else begin
      chk("one_grant", 32'(bus.fe_ready & bus.ex_ready), 0);
      chk("wmask_needs_ex", 32'((bus.mem_wmask != 4'b0000) & ~bus.ex_ready), 0);
      if (bus.fe_rvalid || bus.ex_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rvalid", 32'({bus.fe_rvalid, bus.ex_rvalid}), 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_latency", 32'(e.cyc), 32'(cyc - 1));
          chk("rsp_fe_owner", 32'(bus.fe_rvalid), 32'(e.is_fe));
          chk("rsp_ex_owner", 32'(bus.ex_rvalid), 32'(!e.is_fe));
          chk("rsp_data", bus.fe_rvalid ? bus.fe_rdata : bus.ex_rdata, e.data);
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("missing_rsp", 0, 1);
      end
      if (bus.fe_ready)
        exp_q.push_back('{cyc, 1'b1, ref_mem[bus.fe_addr[7:0]]});
      if (bus.ex_ready && bus.ex_wmask == 4'b0000)
        exp_q.push_back('{cyc, 1'b0, ref_mem[bus.ex_addr[7:0]]});
      if (bus.ex_ready && bus.ex_wmask != 4'b0000)
        for (int b = 0; b < 4; b++)
          if (bus.ex_wmask[b]) ref_mem[bus.ex_addr[7:0]][8*b +: 8] = bus.ex_wdata[8*b +: 8];
      if (bus.fe_valid && !bus.fe_flush && !bus.fe_ready) fe_wait++;
      else fe_wait = 0;
      chk("fe_starve_bound", 32'(fe_wait > STARVE_MAX), 0);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
    bus.mem_rdata = '0;
    bus.fe_addr   = '0;
    bus.ex_addr   = '0;
    bus.ex_wdata  = '0;
    bus.fe_flush  = 1'b0;
    // Requests asserted under reset must not reach the RAM
    bus.fe_valid  = 1'b1;
    bus.ex_valid  = 1'b1;
    bus.ex_wmask  = 4'hf;
    repeat (2) @(negedge clock);
    chk("rst_fe_ready", 32'(bus.fe_ready), 0);
    chk("rst_ex_ready", 32'(bus.ex_ready), 0);
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_mem_wmask", 32'(bus.mem_wmask), 0);
    chk("rst_fe_rvalid", 32'(bus.fe_rvalid), 0);
    chk("rst_ex_rvalid", 32'(bus.ex_rvalid), 0);
    tick();
    reset = 1'b0;
    idle();

    // 1: single FE fetch
    bus.fe_valid = 1'b1; bus.fe_addr = 30'h10;
    @(negedge clock);
    chk("t1_fe_ready", 32'(bus.fe_ready), 1);
    chk("t1_mem_en", 32'(bus.mem_en), 1);
    chk("t1_mem_addr", 32'(bus.mem_addr), 32'h10);
    tick(); idle();
    @(negedge clock);
    chk("t1_fe_rvalid", 32'(bus.fe_rvalid), 1);
    chk("t1_fe_rdata", bus.fe_rdata, 32'h0000_0013);
    tick();

    // 2: both held high -> FE wins every fourth cycle
    bus.fe_valid = 1'b1; bus.fe_addr = 30'h30;
    bus.ex_valid = 1'b1; bus.ex_addr = 30'h31;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("t2_fe_ready", 32'(bus.fe_ready), 32'(k % 4 == 3));
      chk("t2_ex_ready", 32'(bus.ex_ready), 32'(k % 4 != 3));
      tick();
    end
    idle();
    @(negedge clock); tick();

    // 2b: dropping fe_valid clears a partial starvation count
    bus.fe_valid = 1'b1; bus.ex_valid = 1'b1;
    repeat (2) begin @(negedge clock); chk("t2b_ex_first", 32'(bus.ex_ready), 1); tick(); end
    bus.fe_valid = 1'b0;
    @(negedge clock); tick();
    bus.fe_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("t2b_fe_ready", 32'(bus.fe_ready), 32'(k == 3));
      tick();
    end
    idle();
    @(negedge clock); tick();

    // 3: partial EX write then FE read of the same word
    bus.ex_valid = 1'b1; bus.ex_addr = 30'h20; bus.ex_wmask = 4'b0011; bus.ex_wdata = 32'hdead_beef;
    @(negedge clock);
    chk("t3_ex_ready", 32'(bus.ex_ready), 1);
    chk("t3_mem_wmask", 32'(bus.mem_wmask), 32'h3);
    chk("t3_mem_wdata", bus.mem_wdata, 32'hdead_beef);
    tick(); idle();
    bus.fe_valid = 1'b1; bus.fe_addr = 30'h20;
    @(negedge clock);
    chk("t3_no_ex_rvalid", 32'(bus.ex_rvalid), 0);
    chk("t3_fe_ready", 32'(bus.fe_ready), 1);
    tick(); idle();
    @(negedge clock);
    chk("t3_fe_rvalid", 32'(bus.fe_rvalid), 1);
    chk("t3_fe_rdata", bus.fe_rdata, 32'h0000_beef);
    tick();

    // 4: flush blocks FE while EX proceeds
    bus.fe_valid = 1'b1; bus.fe_flush = 1'b1; bus.fe_addr = 30'h10;
    bus.ex_valid = 1'b1; bus.ex_addr = 30'h4;
    @(negedge clock);
    chk("t4_fe_ready", 32'(bus.fe_ready), 0);
    chk("t4_ex_ready", 32'(bus.ex_ready), 1);
    tick(); idle();
    @(negedge clock);
    chk("t4_fe_rvalid", 32'(bus.fe_rvalid), 0);
    chk("t4_ex_rvalid", 32'(bus.ex_rvalid), 1);
    tick();

    // 4b: response already in flight when flush rises is still delivered
    bus.fe_valid = 1'b1; bus.fe_addr = 30'h10;
    @(negedge clock);
    chk("t4b_fe_ready", 32'(bus.fe_ready), 1);
    tick();
    bus.fe_flush = 1'b1;
    @(negedge clock);
    chk("t4b_flush_ready", 32'(bus.fe_ready), 0);
    chk("t4b_fe_rvalid", 32'(bus.fe_rvalid), 1);
    tick(); idle();

    // 5: reset right after an FE grant drops the response
    bus.fe_valid = 1'b1; bus.fe_addr = 30'h10;
    @(negedge clock);
    chk("t5_fe_ready", 32'(bus.fe_ready), 1);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("t5_rst_fe_rvalid", 32'(bus.fe_rvalid), 0);
    chk("t5_rst_mem_en", 32'(bus.mem_en), 0);
    chk("t5_rst_fe_ready", 32'(bus.fe_ready), 0);
    tick();
    reset = 1'b0; idle();
    @(negedge clock);
    chk("t5_post_fe_rvalid", 32'(bus.fe_rvalid), 0);
    tick();
    bus.fe_valid = 1'b1;
    @(negedge clock);
    chk("t5_resume_ready", 32'(bus.fe_ready), 1);
    tick(); idle();
    @(negedge clock);
    chk("t5_resume_rdata", bus.fe_rdata, 32'h0000_0013);
    tick();

    // 6: back-to-back EX reads
    bus.ex_valid = 1'b1; bus.ex_addr = 30'h4;
    @(negedge clock);
    chk("t6_ready0", 32'(bus.ex_ready), 1);
    tick(); bus.ex_addr = 30'h8;
    @(negedge clock);
    chk("t6_rvalid0", 32'(bus.ex_rvalid), 1);
    chk("t6_rdata0", bus.ex_rdata, 32'hC0DE_0004);
    tick(); bus.ex_addr = 30'hc;
    @(negedge clock);
    chk("t6_rvalid1", 32'(bus.ex_rvalid), 1);
    chk("t6_rdata1", bus.ex_rdata, 32'hC0DE_0008);
    tick(); idle();
    @(negedge clock);
    chk("t6_rvalid2", 32'(bus.ex_rvalid), 1);
    chk("t6_rdata2", bus.ex_rdata, 32'hC0DE_000C);
    tick();
    @(negedge clock);
    chk("t6_rvalid_end", 32'(bus.ex_rvalid), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
